// File: rtl/dual_drm_1024x18_if.sv
// Port bundle for the simple dual-port RAM: one write port and one read port sharing a clock.
interface dual_drm_1024x18_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 18
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/dual_drm_1024x18.sv
// Simple dual-port RAM, read-first on same-address collisions, optional second output register.
// Reset clears only the read pipeline; stored words survive it.
module dual_drm_1024x18 #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned OUTPUT_REG = 0
) (
  input logic                   clk,
  input logic                   rst,
  dual_drm_1024x18_if.slave     bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Non-blocking update of mem means this read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[bus.rd_addr];
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
      end else begin
        out_q <= rd_q;
      end
    end

    assign bus.rd_data = out_q;
  end else begin : g_no_out_reg
    assign bus.rd_data = rd_q;
  end
endmodule

// File: tb/tb_dual_drm_1024x18.sv
// Drives a 1-cycle and a 2-cycle build with identical random and directed stimulus and
// compares both against an array-based memory model.
module tb_dual_drm_1024x18;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int Depth = 1 << AW;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;

  dual_drm_1024x18_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  dual_drm_1024x18_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.wr_en   = wr_en;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus0.rd_addr = rd_addr;
  assign bus1.wr_en   = wr_en;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;
  assign bus1.rd_addr = rd_addr;

  dual_drm_1024x18 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  dual_drm_1024x18 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Model: word store plus written-flag; expected outputs for each latency.
  logic [DW-1:0] m_mem [Depth];
  bit            m_vld [Depth];
  logic [DW-1:0] exp1, exp2;
  bit            exp1_v = 1'b0;
  bit            exp2_v = 1'b0;

  always @(posedge clk) begin
    logic [DW-1:0] n1;
    bit            n1v;
    n1  = rst ? '0 : m_mem[rd_addr];
    n1v = rst ? 1'b1 : m_vld[rd_addr];
    exp2   = rst ? '0 : exp1;
    exp2_v = rst ? 1'b1 : exp1_v;
    exp1   = n1;
    exp1_v = n1v;
    if (!rst && wr_en) begin
      m_mem[wr_addr] = wr_data;
      m_vld[wr_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (exp1_v) check("model_lat1", bus0.rd_data, exp1);
    if (exp2_v) check("model_lat2", bus1.rd_data, exp2);
  end

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    @(negedge clk);
  endtask

  initial begin
    // Reset with random reads and writes that must be ignored
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, AW'($urandom), DW'($urandom), AW'($urandom));
      check("reset_rd0", bus0.rd_data, '0);
      check("reset_rd1", bus1.rd_data, '0);
    end

    // Full sweep write then read
    for (int i = 0; i < Depth; i++) begin
      drive(1'b0, 1'b1, AW'(i), DW'(18'h3FFFF - i), AW'($urandom));
    end
    for (int i = 0; i < Depth; i++) begin
      drive(1'b0, 1'b0, '0, '0, AW'(i));
      check("sweep_lat1", bus0.rd_data, DW'(18'h3FFFF - i));
      if (i > 0) check("sweep_lat2", bus1.rd_data, DW'(18'h3FFFF - (i - 1)));
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    check("sweep_lat2_last", bus1.rd_data, DW'(18'h3FFFF - (Depth - 1)));

    // Same-address collision is read-first
    drive(1'b0, 1'b1, 10'd5, 18'h00AAA, 10'd0);
    drive(1'b0, 1'b1, 10'd5, 18'h15555, 10'd5);
    check("collide_old", bus0.rd_data, 18'h00AAA);
    drive(1'b0, 1'b0, 10'd0, 18'h0, 10'd5);
    check("collide_new", bus0.rd_data, 18'h15555);
    check("collide_old_lat2", bus1.rd_data, 18'h00AAA);

    // Top and bottom addresses stay independent
    drive(1'b0, 1'b1, 10'd1023, 18'h12345, 10'd0);
    drive(1'b0, 1'b1, 10'd0, 18'h00001, 10'd1023);
    check("wrap_top", bus0.rd_data, 18'h12345);
    drive(1'b0, 1'b0, 10'd0, 18'h0, 10'd0);
    check("wrap_bottom", bus0.rd_data, 18'h00001);
    drive(1'b0, 1'b0, 10'd0, 18'h0, 10'd1023);
    check("wrap_top_again", bus0.rd_data, 18'h12345);

    // Write blocked by a one-cycle reset
    drive(1'b0, 1'b1, 10'd7, 18'h2AAAA, 10'd7);
    drive(1'b1, 1'b1, 10'd7, 18'h00000, 10'd7);
    check("midrst_clear0", bus0.rd_data, '0);
    check("midrst_clear1", bus1.rd_data, '0);
    drive(1'b0, 1'b0, 10'd0, 18'h0, 10'd7);
    check("midrst_keep", bus0.rd_data, 18'h2AAAA);
    drive(1'b0, 1'b0, 10'd0, 18'h0, 10'd7);
    check("midrst_keep_lat2", bus1.rd_data, 18'h2AAAA);

    // Random traffic, narrow address window half the time to force collisions
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] wa, ra;
      if ($urandom_range(1, 0) == 1) begin
        wa = AW'($urandom_range(15, 0));
        ra = AW'($urandom_range(15, 0));
      end else begin
        wa = AW'($urandom);
        ra = AW'($urandom);
      end
      drive($urandom_range(49, 0) == 0, $urandom_range(2, 0) != 0, wa, DW'($urandom), ra);
    end

    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
